// File: rtl/mac_link_pkg.sv
// Shared types and default constants for the Macintosh keyboard link.
// The enum is the link FSM; the constants are the production defaults.
package mac_link_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CMD      = 2'd1,
        WAIT_RSP = 2'd2,
        RSP      = 2'd3
    } link_state_e;

    localparam int         HALF_BIT_DEF  = 1300;
    localparam int         NULL_TMO_DEF  = 1940;
    localparam logic [7:0] NULL_CODE_DEF = 8'h7B;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a show-ahead head word so the link can pop and load
// its shift register in the same cycle. Full/empty come from a separate count.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head    = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // Storage is not reset: an empty count makes stale words unreachable.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/mac_kbd_link.sv
// Device side of the Macintosh keyboard serial link: clocks a command in from
// the host, then clocks a queued (or null) response back out, MSB first.
module mac_kbd_link
    import mac_link_pkg::*;
#(
    parameter int                DATA_W     = 8,
    parameter int                HALF_BIT   = HALF_BIT_DEF,
    parameter int                FIFO_DEPTH = 4,
    parameter int                NULL_TMO   = NULL_TMO_DEF,
    parameter logic [DATA_W-1:0] NULL_CODE  = DATA_W'(NULL_CODE_DEF)
) (
    input  logic              clk32,
    input  logic              reset,
    input  logic              clk8_en_p,
    input  logic              host_dat_i,
    output logic              dev_clk_o,
    output logic              dev_dat_o,
    output logic [DATA_W-1:0] cmd_data,
    output logic              cmd_strobe,
    input  logic [DATA_W-1:0] rsp_data,
    input  logic              rsp_valid,
    output logic              rsp_ready,
    output logic              busy
);
    localparam int HW = (HALF_BIT > 1) ? $clog2(HALF_BIT) : 1;
    localparam int TW = (NULL_TMO > 1) ? $clog2(NULL_TMO) : 1;
    localparam int BW = (DATA_W > 1)   ? $clog2(DATA_W)   : 1;

    link_state_e       state_q, state_d;
    logic [HW-1:0]     half_q, half_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              dev_clk_q, dev_clk_d;
    logic              dev_dat_q, dev_dat_d;
    logic [DATA_W-1:0] cmd_data_q, cmd_data_d;
    logic              cmd_strobe_q, cmd_strobe_d;

    logic              half_wrap;
    logic              last_bit;
    logic              fifo_pop;
    logic [DATA_W-1:0] fifo_head;
    logic              fifo_full;
    logic              fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk32),
        .rst       (reset),
        .push      (rsp_valid),
        .push_data (rsp_data),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign half_wrap = (half_q == HW'(HALF_BIT - 1));
    assign last_bit  = (bit_q == BW'(DATA_W - 1));

    always_ff @(posedge clk32 or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            half_q       <= '0;
            tmo_q        <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            dev_clk_q    <= 1'b1;
            dev_dat_q    <= 1'b1;
            cmd_data_q   <= '0;
            cmd_strobe_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            half_q       <= half_d;
            tmo_q        <= tmo_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            dev_clk_q    <= dev_clk_d;
            dev_dat_q    <= dev_dat_d;
            cmd_data_q   <= cmd_data_d;
            cmd_strobe_q <= cmd_strobe_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        half_d       = half_q;
        tmo_d        = tmo_q;
        bit_d        = bit_q;
        shift_d      = shift_q;
        dev_clk_d    = dev_clk_q;
        dev_dat_d    = dev_dat_q;
        cmd_data_d   = cmd_data_q;
        cmd_strobe_d = 1'b0;
        fifo_pop     = 1'b0;

        if (clk8_en_p) begin
            half_d = half_wrap ? '0 : half_q + 1'b1;
            unique case (state_q)
                IDLE: begin
                    half_d    = '0;
                    tmo_d     = '0;
                    bit_d     = '0;
                    dev_clk_d = 1'b1;
                    dev_dat_d = 1'b1;
                    if (!host_dat_i) state_d = CMD;
                end
                CMD: begin
                    if (half_wrap) begin
                        dev_clk_d = !dev_clk_q;
                        if (dev_clk_q) begin
                            shift_d = {shift_q[DATA_W-2:0], host_dat_i};
                        end else begin
                            bit_d = bit_q + 1'b1;
                            if (last_bit) begin
                                cmd_data_d   = shift_q;
                                cmd_strobe_d = 1'b1;
                                state_d      = WAIT_RSP;
                                bit_d        = '0;
                                tmo_d        = '0;
                            end
                        end
                    end
                end
                WAIT_RSP: begin
                    // Host still holding data low: the response window has not opened.
                    if (!host_dat_i) begin
                        half_d = '0;
                        tmo_d  = '0;
                    end else if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_head;
                        state_d  = RSP;
                        half_d   = '0;
                        bit_d    = '0;
                        tmo_d    = '0;
                    end else if (half_wrap && fifo_count == '0) begin
                        if (tmo_q == TW'(NULL_TMO - 1)) begin
                            shift_d = NULL_CODE;
                            state_d = RSP;
                            bit_d   = '0;
                            tmo_d   = '0;
                        end else begin
                            tmo_d = tmo_q + 1'b1;
                        end
                    end
                end
                RSP: begin
                    if (half_wrap) begin
                        dev_clk_d = !dev_clk_q;
                        if (dev_clk_q) begin
                            dev_dat_d = shift_q[DATA_W-1];
                            shift_d   = {shift_q[DATA_W-2:0], 1'b0};
                        end else begin
                            bit_d = bit_q + 1'b1;
                            if (last_bit) begin
                                state_d   = IDLE;
                                dev_dat_d = 1'b1;
                                bit_d     = '0;
                            end
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign dev_clk_o  = dev_clk_q;
    assign dev_dat_o  = dev_dat_q;
    assign cmd_data   = cmd_data_q;
    assign cmd_strobe = cmd_strobe_q;
    assign rsp_ready  = !fifo_full;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_mac_kbd_link.sv
// Directed bench for mac_kbd_link: a host model clocks commands in and
// responses out; expected words, latencies and flags are written by hand.
module tb_mac_kbd_link;
    import mac_link_pkg::*;

    logic       clk32 = 1'b0;
    logic       reset = 1'b1;
    logic       clk8_en_p;
    logic       host_dat_i = 1'b1;
    logic       dev_clk_o;
    logic       dev_dat_o;
    logic [7:0] cmd_data;
    logic       cmd_strobe;
    logic [7:0] rsp_data = 8'h00;
    logic       rsp_valid = 1'b0;
    logic       rsp_ready;
    logic       busy;

    logic [1:0] div = 2'd0;
    int         checks = 0;
    int         failures = 0;
    int         falls = 0;
    int         strobes = 0;
    logic       prev_dclk = 1'b1;

    mac_kbd_link #(
        .DATA_W     (8),
        .HALF_BIT   (4),
        .FIFO_DEPTH (4),
        .NULL_TMO   (8),
        .NULL_CODE  (8'h7B)
    ) dut (
        .clk32      (clk32),
        .reset      (reset),
        .clk8_en_p  (clk8_en_p),
        .host_dat_i (host_dat_i),
        .dev_clk_o  (dev_clk_o),
        .dev_dat_o  (dev_dat_o),
        .cmd_data   (cmd_data),
        .cmd_strobe (cmd_strobe),
        .rsp_data   (rsp_data),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .busy       (busy)
    );

    always #5 clk32 = ~clk32;
    always @(posedge clk32) div <= div + 2'd1;
    assign clk8_en_p = (div == 2'd3);

    always @(negedge clk32) begin
        if (prev_dclk && !dev_clk_o) falls++;
        prev_dclk = dev_clk_o;
        if (cmd_strobe) strobes++;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic tfail(input string name);
        checks++;
        failures++;
        $display("FAIL %s: timed out, required event never seen", name);
    endtask

    task automatic wait_dclk(input logic v, output int cyc);
        cyc = 0;
        while (dev_clk_o !== v && cyc < 2000) begin
            @(negedge clk32);
            cyc++;
        end
        if (dev_clk_o !== v) tfail("dev_clk_wait");
    endtask

    task automatic wait_busy();
        int n = 0;
        while (!busy && n < 2000) begin
            @(negedge clk32);
            n++;
        end
        if (!busy) tfail("busy_wait");
    endtask

    // Host pulls data low to start, then presents each bit before the falling edge.
    task automatic send_cmd(input logic [7:0] b);
        int c;
        host_dat_i = 1'b0;
        wait_busy();
        for (int i = 7; i >= 0; i--) begin
            host_dat_i = b[i];
            wait_dclk(1'b0, c);
            wait_dclk(1'b1, c);
        end
        host_dat_i = 1'b0;
        repeat (2) @(negedge clk32);
    endtask

    task automatic recv_rsp(input bit glitch, output logic [7:0] b, output int lat);
        int c;
        lat = 0;
        b = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            wait_dclk(1'b0, c);
            if (i == 7) lat = c;
            b[i] = dev_dat_o;
            if (glitch && i == 5) host_dat_i = 1'b0;
            if (glitch && i == 2) host_dat_i = 1'b1;
            wait_dclk(1'b1, c);
        end
    endtask

    task automatic push_word(input logic [7:0] w);
        int n = 0;
        rsp_data  = w;
        rsp_valid = 1'b1;
        while (!rsp_ready && n < 2000) begin
            @(negedge clk32);
            n++;
        end
        if (!rsp_ready) tfail("push_wait");
        @(negedge clk32);
        rsp_valid = 1'b0;
    endtask

    // Release host data, read the reply and confirm the link returns to IDLE.
    task automatic release_and_check(input string tag, input logic [7:0] exp);
        logic [7:0] got;
        int         lat;
        host_dat_i = 1'b1;
        recv_rsp(1'b0, got, lat);
        check({tag, "_rsp"}, int'(got), int'(exp));
        check({tag, "_idle"}, int'(busy), 0);
        $display("txn %s rsp=%02h exp=%02h", tag, got, exp);
    endtask

    typedef struct {
        logic [7:0] cmd;
        bit         push;
        logic [7:0] word;
        bit         glitch;
        logic [7:0] exp_rsp;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int         f0, s0, lat;
        logic [7:0] got;
        logic [7:0] exp_q[5];

        vecs[0] = '{cmd: 8'hA5, push: 1'b1, word: 8'h3C, glitch: 1'b0, exp_rsp: 8'h3C};
        vecs[1] = '{cmd: 8'h5A, push: 1'b0, word: 8'h00, glitch: 1'b0, exp_rsp: 8'h7B};
        vecs[2] = '{cmd: 8'hFF, push: 1'b1, word: 8'h00, glitch: 1'b1, exp_rsp: 8'h00};
        vecs[3] = '{cmd: 8'h01, push: 1'b1, word: 8'h81, glitch: 1'b0, exp_rsp: 8'h81};

        repeat (3) @(negedge clk32);
        check("rst_dev_clk", int'(dev_clk_o), 1);
        check("rst_dev_dat", int'(dev_dat_o), 1);
        check("rst_strobe", int'(cmd_strobe), 0);
        check("rst_cmd_data", int'(cmd_data), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_ready", int'(rsp_ready), 1);
        reset = 1'b0;
        repeat (4) @(negedge clk32);

        for (int v = 0; v < 4; v++) begin
            if (vecs[v].push) push_word(vecs[v].word);
            f0 = falls;
            s0 = strobes;
            send_cmd(vecs[v].cmd);
            check("cmd_data", int'(cmd_data), int'(vecs[v].cmd));
            check("cmd_falls", falls - f0, 8);
            check("cmd_strobes", strobes - s0, 1);
            check("wait_state", int'(dut.state_q), int'(WAIT_RSP));
            f0 = falls;
            host_dat_i = 1'b1;
            recv_rsp(vecs[v].glitch, got, lat);
            check("rsp_word", int'(got), int'(vecs[v].exp_rsp));
            check("rsp_falls", falls - f0, 8);
            if (vecs[v].push) check("pop_latency", int'(lat >= 12 && lat <= 24), 1);
            else              check("null_latency", int'(lat >= 136 && lat <= 152), 1);
            check("end_busy", int'(busy), 0);
            check("end_dev_dat", int'(dev_dat_o), 1);
            $display("txn vec%0d cmd=%02h rsp=%02h exp=%02h lat=%0d", v, vecs[v].cmd, got, vecs[v].exp_rsp, lat);
        end

        // Five words into a four-deep FIFO: the fifth waits for the first pop.
        exp_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        for (int k = 0; k < 4; k++) begin
            check("ready_before_push", int'(rsp_ready), 1);
            push_word(exp_q[k]);
        end
        check("ready_full", int'(rsp_ready), 0);
        check("count_full", int'(dut.u_fifo.count), 4);
        fork
            push_word(exp_q[4]);
            begin
                repeat (10) @(negedge clk32);
                check("ready_held", int'(rsp_ready), 0);
                for (int k = 0; k < 5; k++) begin
                    send_cmd(8'h10 + 8'(k));
                    release_and_check("order", exp_q[k]);
                end
            end
        join

        // Push lands in the very cycle the FSM pops, with two words queued.
        push_word(8'h66);
        push_word(8'h77);
        send_cmd(8'h20);
        check("count_pre", int'(dut.u_fifo.count), 2);
        while (!clk8_en_p) @(negedge clk32);
        host_dat_i = 1'b1;
        rsp_data   = 8'h88;
        rsp_valid  = 1'b1;
        @(negedge clk32);
        rsp_valid = 1'b0;
        check("count_same", int'(dut.u_fifo.count), 2);
        check("rsp_state", int'(dut.state_q), int'(RSP));
        recv_rsp(1'b0, got, lat);
        check("pp_first", int'(got), 8'h66);
        $display("txn pushpop rsp=%02h exp=66", got);
        send_cmd(8'h21);
        release_and_check("pp_second", 8'h77);
        send_cmd(8'h22);
        release_and_check("pp_third", 8'h88);

        // Reset partway through a command, with a word waiting in the FIFO.
        push_word(8'h99);
        s0 = strobes;
        host_dat_i = 1'b0;
        wait_busy();
        for (int i = 7; i >= 4; i--) begin
            host_dat_i = (i % 2 == 0) ? 1'b1 : 1'b0;
            wait_dclk(1'b0, lat);
            if (i != 4) wait_dclk(1'b1, lat);
        end
        reset = 1'b1;
        #1;
        check("mid_rst_dev_clk", int'(dev_clk_o), 1);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_ready", int'(rsp_ready), 1);
        check("mid_rst_count", int'(dut.u_fifo.count), 0);
        check("mid_rst_cmd_data", int'(cmd_data), 0);
        @(negedge clk32);
        reset = 1'b0;
        host_dat_i = 1'b1;
        repeat (4) @(negedge clk32);
        check("mid_rst_strobes", strobes - s0, 0);
        $display("txn midreset strobes=%0d", strobes - s0);
        s0 = strobes;
        send_cmd(8'h96);
        check("after_rst_cmd", int'(cmd_data), 8'h96);
        check("after_rst_strobe", strobes - s0, 1);
        release_and_check("after_rst_null", 8'h7B);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mac_kbd_link.md
MAC_KBD_LINK -- requirements
Module: mac_kbd_link

Interface
REQ-001 Parameter DATA_W, default 8: bits per command and per response frame.
REQ-002 Parameter HALF_BIT, default 1300: clk8_en_p ticks per clock half-period (~165 us).
REQ-003 Parameter FIFO_DEPTH, default 4: response FIFO entries; power of 2, at least 2.
REQ-004 Parameter NULL_TMO, default 1940: half-bit periods waited in WAIT_RSP before the null response is sent.
REQ-005 Parameter NULL_CODE, default 8'h7B: null response word.
REQ-006 Port clk32, input, 1: system clock; single clock domain.
REQ-007 Port reset, input, 1: asynchronous, active-high reset.
REQ-008 Port clk8_en_p, input, 1: clock enable; all state except the FIFO and strobes advances only when it is high.
REQ-009 Port host_dat_i, input, 1: host data line, already resolved as ~oe|o.
REQ-010 Port dev_clk_o, output, 1: device clock line to host (VIA CB1).
REQ-011 Port dev_dat_o, output, 1: device data line to host (VIA CB2 input).
REQ-012 Port cmd_data, output, DATA_W: last command received from the host.
REQ-013 Port cmd_strobe, output, 1: one-clk32 pulse when cmd_data is updated.
REQ-014 Port rsp_data, input, DATA_W: response word from the keyboard model.
REQ-015 Port rsp_valid, input, 1: push request.
REQ-016 Port rsp_ready, output, 1: FIFO not full; a push occurs when rsp_valid and rsp_ready are both high.
REQ-017 Port busy, output, 1: FSM is not in IDLE.

Function
REQ-018 FSM states: IDLE, CMD, WAIT_RSP, RSP.
REQ-019 IDLE→CMD on a tick with host_dat_i=0; bit counter cleared.
REQ-020 Half-bit counter runs in CMD and RSP (and in WAIT_RSP for the timeout only); it counts ticks 0..HALF_BIT-1, wraps, and toggles dev_clk_o on wrap in CMD/RSP.
REQ-021 Frame: dev_clk_o idle 1; per bit, one low half then one high half; DATA_W low pulses per frame.
REQ-022 CMD: on the 1→0 toggle, shift host_dat_i into the shift register LSB (MSB-first).
REQ-023 CMD: on the DATA_W-th 0→1 toggle, load cmd_data, pulse cmd_strobe in the same clk32 cycle, and go to WAIT_RSP.
REQ-024 WAIT_RSP→RSP once host_dat_i=1 and the FIFO is non-empty: pop the head into the shift register.
REQ-025 WAIT_RSP with host_dat_i=1 and FIFO empty for NULL_TMO half-bit periods: load NULL_CODE and go to RSP.
REQ-026 WAIT_RSP with host_dat_i=0 holds the timeout counter at 0.
REQ-027 RSP: on each 1→0 toggle, drive dev_dat_o = shift MSB, then shift left.
REQ-028 RSP: on the DATA_W-th 0→1 toggle, go to IDLE and set dev_dat_o=1.
REQ-029 dev_dat_o = 1 outside RSP.
REQ-030 FIFO: push is independent of clk8_en_p.
REQ-031 FIFO: rsp_ready = !full.
REQ-032 FIFO: a pop occurs only on the REQ-024 transition.
REQ-033 FIFO: simultaneous push and pop are both honoured, with the count unchanged.
REQ-034 FIFO: a push into an empty FIFO is not poppable until the next cycle.
REQ-035 Pointers are log2(FIFO_DEPTH) bits and wrap modulo depth; a separate count of log2(FIFO_DEPTH)+1 bits provides full and empty.
REQ-036 In RSP, host_dat_i is ignored.
REQ-037 A host_dat_i low while in RSP does not abort the frame.

Reset
REQ-038 reset forces IDLE.
REQ-039 reset sets dev_clk_o=1, dev_dat_o=1, cmd_strobe=0, cmd_data=0, busy=0.
REQ-040 reset clears the FIFO (empty, rsp_ready=1) and all counters.
REQ-041 Reset mid-frame abandons the frame with no strobe and no pop; operation resumes in IDLE on the first clk32 edge after deassertion.

Structure
REQ-042 Package mac_link_pkg holds the state enum and default constants (HALF_BIT, NULL_CODE, NULL_TMO).
REQ-043 The response FIFO is sub-module sync_fifo (parameters WIDTH and DEPTH; ports push, pop, full, empty, count).

Verification (HALF_BIT=4, NULL_TMO=8, clk8_en_p every 4th cycle)
REQ-044 Host drives 8'hA5 MSB-first, sampled on falling dev_clk_o → exactly 8 low pulses; cmd_data=8'hA5; one cmd_strobe; state WAIT_RSP.
REQ-045 Push 8'h3C, then the host releases data after the command → dev_dat_o serialises 0,0,1,1,1,1,0,0 on the falling edges; IDLE afterwards with dev_dat_o=1.
REQ-046 Empty FIFO and the host releases data → after 8 half-bit periods, 8'h7B is shifted out.
REQ-047 Push 5 words with FIFO_DEPTH=4 → rsp_ready drops after the 4th push; the 5th is held by the source; words are later delivered in push order.
REQ-048 reset asserted at bit 3 of a command → immediate IDLE with dev_clk_o=1, no cmd_strobe, FIFO empty; the next command completes normally.
REQ-049 Push and pop in the same cycle with count=2 → count stays 2 and order is preserved.
